// File: rtl/uart_tx_gen2.sv
// rtl/uart_tx_gen2.sv - UART transmitter: TX FIFO, oversampled bit timer, FIFO-level interrupt
// Define UART_TX_CTS_EN to add the cts_ni clear-to-send input.
module uart_tx_gen2 #(
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16
) (
`ifdef UART_TX_CTS_EN
  input  logic                        cts_ni,
`endif
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        os_tick_i,
  input  logic                        cfg_tx_en_i,
  input  logic [3:0]                  cfg_data_bits_i,
  input  logic                        cfg_par_en_i,
  input  logic [1:0]                  cfg_par_mode_i,
  input  logic [1:0]                  cfg_stop_i,
  input  logic                        cfg_break_i,
  input  logic                        fifo_flush_i,
  input  logic [MAX_DATA_BITS-1:0]    wdata_i,
  input  logic                        wvalid_i,
  output logic                        wready_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_usage_o,
  input  logic [$clog2(FIFO_DEPTH):0] thresh_i,
  output logic                        thresh_irq_o,
  output logic                        tx_empty_o,
  output logic                        busy_o,
  output logic                        txd_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2 * OVERSAMPLE);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic cts_n;
`ifdef UART_TX_CTS_EN
  assign cts_n = cts_ni;
`else
  assign cts_n = 1'b0;
`endif

  logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wptr_q, rptr_q;
  logic [AW:0]              usage_q, usage_d;
  logic                     fifo_empty, push, pop;

  state_e                   state_q;
  logic [TW-1:0]            tcnt_q, last_tick;
  logic [3:0]               bidx_q, nb_q, nb_cfg;
  logic [MAX_DATA_BITS-1:0] shift_q, mask, head, load_data;
  logic                     par_en_q, par_q, load_par, txd_q;
  logic [1:0]               stop_q;
  logic                     bit_end, can_start;

  assign fifo_empty = (usage_q == '0);
  assign wready_o   = (usage_q != (AW+1)'(FIFO_DEPTH));
  assign push       = wvalid_i & wready_o & ~fifo_flush_i;
  assign head       = mem_q[rptr_q];
  assign usage_d    = usage_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  // A flush wins over both push and pop; a pop in that cycle still feeds the FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else if (fifo_flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      usage_q <= usage_d;
    end
  end

  always_comb begin
    nb_cfg = cfg_data_bits_i;
    if (cfg_data_bits_i < 4'd5) nb_cfg = 4'd5;
    else if (cfg_data_bits_i > 4'(MAX_DATA_BITS)) nb_cfg = 4'(MAX_DATA_BITS);
    mask      = ~({MAX_DATA_BITS{1'b1}} << nb_cfg);
    load_data = head & mask;
    case (cfg_par_mode_i)
      2'b00:   load_par = ~^load_data;
      2'b01:   load_par = ^load_data;
      2'b10:   load_par = 1'b1;
      default: load_par = 1'b0;
    endcase
  end

  always_comb begin
    last_tick = TW'(OVERSAMPLE - 1);
    if (state_q == STOP) begin
      if (stop_q[1])      last_tick = TW'(2 * OVERSAMPLE - 1);
      else if (stop_q[0]) last_tick = TW'(3 * OVERSAMPLE / 2 - 1);
    end
  end

  assign bit_end   = os_tick_i & (tcnt_q == last_tick);
  assign can_start = cfg_tx_en_i & ~fifo_empty & ~cts_n;
  assign pop       = can_start & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      nb_q     <= 4'd5;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop_q   <= '0;
      txd_q    <= 1'b1;
    end else begin
      // The line follows the state with one cycle of lag; break overrides it.
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[0];
        PARITY:  txd_q <= par_q;
        default: txd_q <= 1'b1;
      endcase
      if (cfg_break_i) txd_q <= 1'b0;

      if (pop) begin
        state_q  <= START;
        tcnt_q   <= '0;
        shift_q  <= load_data;
        nb_q     <= nb_cfg;
        par_en_q <= cfg_par_en_i;
        par_q    <= load_par;
        stop_q   <= cfg_stop_i;
      end else if (state_q != IDLE && os_tick_i) begin
        if (bit_end) begin
          tcnt_q <= '0;
          case (state_q)
            START: begin
              state_q <= DATA;
              bidx_q  <= '0;
            end
            DATA: begin
              shift_q <= shift_q >> 1;
              if (bidx_q == nb_q - 4'd1) state_q <= par_en_q ? PARITY : STOP;
              else                       bidx_q  <= bidx_q + 4'd1;
            end
            PARITY:  state_q <= STOP;
            default: state_q <= IDLE;
          endcase
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
        end
      end
    end
  end

  assign txd_o        = txd_q;
  assign busy_o       = (state_q != IDLE);
  assign tx_empty_o   = fifo_empty & (state_q == IDLE);
  assign fifo_usage_o = usage_q;
  assign thresh_irq_o = (usage_q <= thresh_i);

endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb/tb_uart_tx_gen2.sv - directed self-checking bench for uart_tx_gen2
module tb_uart_tx_gen2;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       os_tick_i, cfg_tx_en_i, cfg_par_en_i, cfg_break_i, fifo_flush_i, wvalid_i;
  logic [3:0] cfg_data_bits_i;
  logic [1:0] cfg_par_mode_i, cfg_stop_i;
  logic [8:0] wdata_i;
  logic [4:0] thresh_i, fifo_usage_o;
  logic       wready_o, thresh_irq_o, tx_empty_o, busy_o, txd_o;
  logic       cts_ni = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  uart_tx_gen2 dut (
`ifdef UART_TX_CTS_EN
    .cts_ni          (cts_ni),
`endif
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .os_tick_i       (os_tick_i),
    .cfg_tx_en_i     (cfg_tx_en_i),
    .cfg_data_bits_i (cfg_data_bits_i),
    .cfg_par_en_i    (cfg_par_en_i),
    .cfg_par_mode_i  (cfg_par_mode_i),
    .cfg_stop_i      (cfg_stop_i),
    .cfg_break_i     (cfg_break_i),
    .fifo_flush_i    (fifo_flush_i),
    .wdata_i         (wdata_i),
    .wvalid_i        (wvalid_i),
    .wready_o        (wready_o),
    .fifo_usage_o    (fifo_usage_o),
    .thresh_i        (thresh_i),
    .thresh_irq_o    (thresh_irq_o),
    .tx_empty_o      (tx_empty_o),
    .busy_o          (busy_o),
    .txd_o           (txd_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [8:0] v);
    wdata_i  = v;
    wvalid_i = 1'b1;
    @(negedge clk_i);
    wvalid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int i = 0;
    while (busy_o && i < lim) begin
      @(negedge clk_i);
      i++;
    end
    chk(tag, busy_o, 0);
  endtask

  // Samples each bit at mid-period (os_tick every cycle, 16 cycles per bit).
  task automatic rx_frame(input int nbits, input bit par_en, input int hi_lim,
                          output logic [8:0] data, output logic par, output int wait_cyc,
                          output int usage0, output int stop_hi);
    wait_cyc = 0;
    data     = '0;
    par      = 1'b0;
    stop_hi  = 0;
    while (txd_o !== 1'b0 && wait_cyc < 2000) begin
      @(negedge clk_i);
      wait_cyc++;
    end
    usage0 = int'(fifo_usage_o);
    repeat (8) @(negedge clk_i);
    chk("rx_start", txd_o, 0);
    for (int i = 0; i < nbits; i++) begin
      repeat (16) @(negedge clk_i);
      data[i] = txd_o;
    end
    if (par_en) begin
      repeat (16) @(negedge clk_i);
      par = txd_o;
    end
    repeat (8) @(negedge clk_i);
    while (txd_o === 1'b1 && stop_hi < hi_lim) begin
      stop_hi++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] d;
    logic       p;
    int         w, u, hi, frame_cyc, k;

    os_tick_i = 1'b1; cfg_tx_en_i = 1'b1; cfg_data_bits_i = 4'd8; cfg_par_en_i = 1'b0;
    cfg_par_mode_i = 2'b00; cfg_stop_i = 2'b00; cfg_break_i = 1'b0; fifo_flush_i = 1'b0;
    wdata_i = '0; wvalid_i = 1'b0; thresh_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_txd", txd_o, 1);
    chk("rst_wready", wready_o, 1);
    chk("rst_usage", fifo_usage_o, 0);
    chk("rst_tx_empty", tx_empty_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_irq", thresh_irq_o, 1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 8N1 0x55
    push(9'h055);
    frame_cyc = 0;
    fork
      rx_frame(8, 1'b0, 16, d, p, w, u, hi);
      begin
        for (int i = 0; i < 400; i++) begin
          if (busy_o) frame_cyc++;
          else if (frame_cyc > 0) break;
          @(negedge clk_i);
        end
      end
    join
    chk("t2_data", d, 9'h055);
    chk("t2_stop", hi, 16);
    chk("t2_frame_cycles", frame_cyc, 160);
    chk("t2_tx_empty", tx_empty_o, 1);

    cfg_break_i = 1'b1;
    @(negedge clk_i);
    chk("break_low", txd_o, 0);
    cfg_break_i = 1'b0;
    @(negedge clk_i);
    chk("break_release", txd_o, 1);

    os_tick_i = 1'b0;
    push(9'h000);
    repeat (20) @(negedge clk_i);
    chk("stall_busy", busy_o, 1);
    chk("stall_txd", txd_o, 0);
    os_tick_i = 1'b1;
    wait_idle("stall_resume_idle", 400);

    // 7E2 frame; config changed right after the pop so frames 2/3 use 9O1.5
    cfg_tx_en_i = 1'b0; cfg_data_bits_i = 4'd7; cfg_par_en_i = 1'b1;
    cfg_par_mode_i = 2'b01; cfg_stop_i = 2'b10;
    push(9'h041); push(9'h1A5); push(9'h0F0);
    cfg_tx_en_i = 1'b1;
    @(negedge clk_i);
    cfg_data_bits_i = 4'd9; cfg_par_mode_i = 2'b00; cfg_stop_i = 2'b01;
    rx_frame(7, 1'b1, 100, d, p, w, u, hi);
    chk("t3a_data", d, 9'h041);
    chk("t3a_par", p, 0);
    chk("t3a_stop", hi, 32);
    rx_frame(9, 1'b1, 100, d, p, w, u, hi);
    chk("t3b_data", d, 9'h1A5);
    chk("t3b_par", p, 0);
    chk("t3b_stop", hi, 24);
    chk("t3b_gap", w, 0);
    rx_frame(9, 1'b1, 24, d, p, w, u, hi);
    chk("t3c_data", d, 9'h0F0);
    chk("t3c_par", p, 1);

    // 3 data bits clamps to 5; parity forced to 1
    cfg_data_bits_i = 4'd3; cfg_par_mode_i = 2'b10; cfg_stop_i = 2'b00;
    push(9'h1F5);
    rx_frame(5, 1'b1, 16, d, p, w, u, hi);
    chk("clamp_data", d, 9'h015);
    chk("clamp_par", p, 1);

    // Fill, overflow, then drain back-to-back
    cfg_data_bits_i = 4'd8; cfg_par_en_i = 1'b0; cfg_tx_en_i = 1'b0;
    for (int i = 0; i < 16; i++) push(9'(16 + i));
    chk("t4_usage_full", fifo_usage_o, 16);
    chk("t4_wready_full", wready_o, 0);
    push(9'h0EE);
    chk("t4_drop", fifo_usage_o, 16);
    cfg_tx_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_frame(8, 1'b0, (i == 15) ? 16 : 100, d, p, w, u, hi);
      chk($sformatf("t4_data%0d", i), d, 32'(16 + i));
      chk($sformatf("t4_usage%0d", i), u, 32'(15 - i));
      if (i > 0) chk($sformatf("t4_gap%0d", i), w, 0);
    end
    repeat (5) @(negedge clk_i);
    chk("t4_tx_empty", tx_empty_o, 1);
    chk("t4_usage_end", fifo_usage_o, 0);

    // Threshold interrupt and flush during a frame
    thresh_i = 5'd4; cfg_tx_en_i = 1'b0;
    for (int i = 0; i < 6; i++) push(9'(8'h31 + i));
    chk("t5_usage6", fifo_usage_o, 6);
    chk("t5_irq_low", thresh_irq_o, 0);
    cfg_tx_en_i = 1'b1;
    @(negedge clk_i);
    chk("t5_usage5", fifo_usage_o, 5);
    chk("t5_irq_at5", thresh_irq_o, 0);
    k = 0;
    while (fifo_usage_o == 5'd5 && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    chk("t5_usage4", fifo_usage_o, 4);
    chk("t5_irq_rise", thresh_irq_o, 1);
    rx_frame(8, 1'b0, 100, d, p, w, u, hi);
    chk("t5_f2_data", d, 9'h032);
    fork
      rx_frame(8, 1'b0, 16, d, p, w, u, hi);
      begin
        chk("t5_usage3", fifo_usage_o, 3);
        repeat (28) @(negedge clk_i);
        fifo_flush_i = 1'b1;
        wdata_i = 9'h099;
        wvalid_i = 1'b1;
        @(negedge clk_i);
        fifo_flush_i = 1'b0;
        wvalid_i = 1'b0;
        chk("t5_flush_usage", fifo_usage_o, 0);
        chk("t5_flush_busy", busy_o, 1);
      end
    join
    chk("t5_f3_data", d, 9'h033);
    chk("t5_f3_stop", hi, 16);
    repeat (20) @(negedge clk_i);
    chk("t5_idle_busy", busy_o, 0);
    chk("t5_idle_empty", tx_empty_o, 1);

`ifdef UART_TX_CTS_EN
    cts_ni = 1'b1;
    push(9'h0A3);
    repeat (40) @(negedge clk_i);
    chk("t6_blocked_busy", busy_o, 0);
    chk("t6_blocked_usage", fifo_usage_o, 1);
    cts_ni = 1'b0;
    @(negedge clk_i);
    chk("t6_start", busy_o, 1);
    push(9'h05A);
    fork
      rx_frame(8, 1'b0, 16, d, p, w, u, hi);
      begin
        repeat (60) @(negedge clk_i);
        cts_ni = 1'b1;
      end
    join
    chk("t6_data", d, 9'h0A3);
    repeat (200) @(negedge clk_i);
    chk("t6_no_follow_busy", busy_o, 0);
    chk("t6_no_follow_usage", fifo_usage_o, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
